// File: rtl/qf_wb_arbiter2_if.sv
// Wishbone classic link between one master and one slave.
// dat_w carries write data towards the slave, dat_r carries read data back.
interface qf_wb_arbiter2_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [DW/8-1:0] sel;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic            ack;
    logic            err;

    // Bus master side: drives the request, receives the response.
    modport master (
        output cyc, stb, we, sel, adr, dat_w,
        input  dat_r, ack, err
    );

    // Bus slave side: receives the request, drives the response.
    modport slave (
        input  cyc, stb, we, sel, adr, dat_w,
        output dat_r, ack, err
    );
endinterface

// File: rtl/qf_wb_arbiter2.sv
// Two-master / one-slave Wishbone classic arbiter.
// m0 is the management SoC port, m1 the on-chip CPU. Round-robin grant held for
// a whole bus cycle, with a stb-without-ack watchdog that ends hung beats with
// err and raises a one-cycle irq pulse.
module qf_wb_arbiter2 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rstn_i,
    qf_wb_arbiter2_if.slave        m0,
    qf_wb_arbiter2_if.slave        m1,
    qf_wb_arbiter2_if.master       s,
    output logic [1:0]             grant_o,
    output logic                   timeout_irq_o
);

    // A zero-width counter is illegal, so a disabled watchdog keeps one dummy bit.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            irq_q, irq_d;

    logic            gnt0;
    logic            gnt1;
    logic            sel_cyc;
    logic            sel_stb;
    logic            sel_we;
    logic [DW/8-1:0] sel_sel;
    logic [AW-1:0]   sel_adr;
    logic [DW-1:0]   sel_dat;
    logic            timeout_hit;

    assign gnt0 = (state_q == GNT0);
    assign gnt1 = (state_q == GNT1);

    // Grant comes straight from the state register, so it is glitch-free.
    assign grant_o       = {gnt1, gnt0};
    assign timeout_irq_o = irq_q;

    // Select the granted master's request; everything is zero while idle.
    always_comb begin
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        sel_we  = 1'b0;
        sel_sel = '0;
        sel_adr = '0;
        sel_dat = '0;
        if (gnt0) begin
            sel_cyc = m0.cyc;
            sel_stb = m0.stb;
            sel_we  = m0.we;
            sel_sel = m0.sel;
            sel_adr = m0.adr;
            sel_dat = m0.dat_w;
        end else if (gnt1) begin
            sel_cyc = m1.cyc;
            sel_stb = m1.stb;
            sel_we  = m1.we;
            sel_sel = m1.sel;
            sel_adr = m1.adr;
            sel_dat = m1.dat_w;
        end
    end

    // The watchdog fires on the last allowed waiting beat unless the slave acks
    // in that very cycle (ack wins), so ack and err can never coincide.
    assign timeout_hit = (TIMEOUT > 0) && sel_cyc && sel_stb && !s.ack
                         && (cnt_q == CNT_LAST);

    // Drive the slave; stb is suppressed in the timeout cycle so the slave
    // never sees a beat the master is being told has failed.
    always_comb begin
        s.cyc   = sel_cyc;
        s.stb   = sel_stb && !timeout_hit;
        s.we    = sel_we;
        s.sel   = sel_sel;
        s.adr   = sel_adr;
        s.dat_w = sel_dat;
    end

    // Return the slave response to the granted master only (zero added latency).
    always_comb begin
        m0.ack   = gnt0 && s.ack;
        m0.err   = gnt0 && timeout_hit;
        m0.dat_r = gnt0 ? s.dat_r : '0;
        m1.ack   = gnt1 && s.ack;
        m1.err   = gnt1 && timeout_hit;
        m1.dat_r = gnt1 ? s.dat_r : '0;
    end

    // Arbitration: grant from IDLE only, round-robin on contention, and
    // always return through IDLE when the owner drops cyc.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0.cyc) begin
                    state_d = GNT0;
                end else if (m1.cyc) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0.cyc) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                end
            end
            GNT1: begin
                if (!m1.cyc) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Watchdog counter: counts waiting strobe beats, clears on ack, stb low,
    // idle or a fired timeout, and saturates instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (TIMEOUT == 0 || !sel_cyc || !sel_stb || s.ack || timeout_hit) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
        irq_d = timeout_hit;
    end

    // State registers with synchronous active-low reset; m0 wins the first tie.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
        end
    end

endmodule

// File: tb/tb_qf_wb_arbiter2.sv
// Directed bench for qf_wb_arbiter2 (TIMEOUT=8). Stimulus pushes the expected
// master response into a queue; a monitor pops and compares on every ack/err.
module tb_qf_wb_arbiter2;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        int          m;
        bit          is_err;
        logic [31:0] dat;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic [1:0]  grant;
    logic        irq;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    qf_wb_arbiter2_if #(.AW(AW), .DW(DW)) m0_if ();
    qf_wb_arbiter2_if #(.AW(AW), .DW(DW)) m1_if ();
    qf_wb_arbiter2_if #(.AW(AW), .DW(DW)) s_if ();

    qf_wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .wb_clk_i      (clk),
        .wb_rstn_i     (rstn),
        .m0            (m0_if),
        .m1            (m1_if),
        .s             (s_if),
        .grant_o       (grant),
        .timeout_irq_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_m0(input logic cyc, input logic stb, input logic we,
                          input logic [31:0] adr, input logic [31:0] dat);
        m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we;
        m0_if.sel = 4'hF; m0_if.adr = adr; m0_if.dat_w = dat;
    endtask

    task automatic set_m1(input logic cyc, input logic stb, input logic we,
                          input logic [31:0] adr, input logic [31:0] dat);
        m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we;
        m1_if.sel = 4'h3; m1_if.adr = adr; m1_if.dat_w = dat;
    endtask

    task automatic push(input int m, input bit is_err, input logic [31:0] dat);
        exp_t e;
        e.m = m; e.is_err = is_err; e.dat = dat;
        exp_q.push_back(e);
    endtask

    // Monitor: every master-visible response must match the next expected one.
    always @(negedge clk) begin
        if (m0_if.ack || m0_if.err || m1_if.ack || m1_if.err) begin
            int          gm;
            bit          gerr;
            logic [31:0] gdat;
            gm   = (m1_if.ack || m1_if.err) ? 1 : 0;
            gerr = (gm == 1) ? m1_if.err : m0_if.err;
            gdat = (gm == 1) ? m1_if.dat_r : m0_if.dat_r;
            $display("%0t resp m%0d %s dat=%h", $time, gm, gerr ? "err" : "ack", gdat);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: got m%0d err=%0d dat=%h, required none", gm, gerr, gdat);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ((m0_if.ack || m0_if.err) && (m1_if.ack || m1_if.err)) begin
                    errors++;
                    $display("FAIL resp_both: both masters responded, required only m%0d", e.m);
                end else if ((m0_if.ack && m0_if.err) || (m1_if.ack && m1_if.err)) begin
                    errors++;
                    $display("FAIL resp_ack_err: ack and err together, required m%0d err=%0d", e.m, e.is_err);
                end else if (gm != e.m || gerr != e.is_err || (!e.is_err && gdat !== e.dat)) begin
                    errors++;
                    $display("FAIL resp: got m%0d err=%0d dat=%h, required m%0d err=%0d dat=%h",
                             gm, gerr, gdat, e.m, e.is_err, e.dat);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0);
        s_if.ack = 1'b0; s_if.err = 1'b0; s_if.dat_r = '0;

        // ---- 1: reset state, m0 single read with 2-cycle slave latency
        nxt(); nxt(); smp();
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_cyc", s_if.cyc, 0);
        chk("rst_s_stb", s_if.stb, 0);
        chk("rst_irq", irq, 0);
        chk("rst_m0_ack", m0_if.ack, 0);
        chk("rst_s_adr", s_if.adr, 0);
        nxt();
        rstn = 1'b1;
        set_m0(1, 1, 0, 32'h0000_0100, 0);
        smp();
        chk("t1_arb_s_cyc", s_if.cyc, 0);
        chk("t1_arb_grant", grant, 2'b00);
        nxt(); smp();
        chk("t1_grant", grant, 2'b01);
        chk("t1_s_cyc", s_if.cyc, 1);
        chk("t1_s_adr", s_if.adr, 32'h100);
        chk("t1_s_we", s_if.we, 0);
        nxt(); smp();
        nxt();
        s_if.ack = 1'b1; s_if.dat_r = 32'hCAFE_F00D;
        push(0, 0, 32'hCAFE_F00D);
        smp();
        chk("t1_m0_dat", m0_if.dat_r, 32'hCAFE_F00D);
        chk("t1_m1_dat", m1_if.dat_r, 0);
        nxt();
        s_if.ack = 1'b0; s_if.dat_r = '0;
        set_m0(0, 0, 0, 0, 0);
        smp();
        chk("t1_drop_s_cyc", s_if.cyc, 0);
        chk("t1_drop_grant", grant, 2'b01);
        nxt(); smp();
        chk("t1_idle_grant", grant, 2'b00);

        // ---- 2: simultaneous requests after reset alternate 01,10,01,10
        nxt(); rstn = 1'b0;
        nxt(); rstn = 1'b1;
        set_m0(1, 1, 0, 32'h0000_0200, 0);
        set_m1(1, 1, 0, 32'h0000_0210, 0);
        nxt();
        for (int i = 0; i < 4; i++) begin
            int g;
            g = i % 2;
            s_if.ack = 1'b1; s_if.dat_r = 32'h2000_0000 + i;
            push(g, 0, 32'h2000_0000 + i);
            smp();
            chk("t2_grant", grant, (g == 1) ? 2'b10 : 2'b01);
            chk("t2_s_adr", s_if.adr, (g == 1) ? 32'h210 : 32'h200);
            nxt();
            s_if.ack = 1'b0;
            if (g == 1) set_m1(0, 0, 0, 32'h210, 0);
            else        set_m0(0, 0, 0, 32'h200, 0);
            smp();
            chk("t2_drop_s_cyc", s_if.cyc, 0);
            nxt();
            if (g == 1) set_m1(1, 1, 0, 32'h210, 0);
            else        set_m0(1, 1, 0, 32'h200, 0);
            smp();
            chk("t2_idle_grant", grant, 2'b00);
            nxt();
        end
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0);
        nxt(); nxt();

        // ---- 3: m1 holds cyc for 4 write beats while m0 waits
        set_m1(1, 0, 1, 32'h0000_0300, 0);
        nxt();
        set_m0(1, 1, 0, 32'h0000_0380, 0);
        for (int b = 0; b < 4; b++) begin
            set_m1(1, 1, 1, 32'h300 + 4 * b, 32'hA0 + b);
            s_if.ack = 1'b1; s_if.dat_r = 32'h5A5A_0000 + b;
            push(1, 0, 32'h5A5A_0000 + b);
            smp();
            chk("t3_grant", grant, 2'b10);
            chk("t3_s_dat", s_if.dat_w, 32'hA0 + b);
            chk("t3_s_sel", s_if.sel, 4'h3);
            chk("t3_m0_ack", m0_if.ack, 0);
            nxt();
            set_m1(1, 0, 1, 32'h300, 0);
            s_if.ack = 1'b0;
            smp();
            chk("t3_gap_grant", grant, 2'b10);
            nxt();
        end
        set_m1(0, 0, 0, 0, 0);
        nxt(); smp();
        chk("t3_idle_grant", grant, 2'b00);
        nxt();
        s_if.ack = 1'b1; s_if.dat_r = 32'h3333_0380;
        push(0, 0, 32'h3333_0380);
        smp();
        chk("t3_m0_grant", grant, 2'b01);
        nxt();
        s_if.ack = 1'b0;
        set_m0(0, 0, 0, 0, 0);
        nxt(); nxt();

        // ---- 4: slave never acks -> err on 8th stb cycle, irq one cycle later
        set_m0(1, 1, 1, 32'h0000_0400, 32'h44);
        nxt();
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) push(0, 1, 0);
            smp();
            chk("t4_s_stb", s_if.stb, (c < 8) ? 1 : 0);
            chk("t4_m0_err", m0_if.err, (c == 8) ? 1 : 0);
            chk("t4_irq", irq, 0);
            nxt();
        end
        set_m0(0, 0, 0, 0, 0);
        smp();
        chk("t4_irq_pulse", irq, 1);
        chk("t4_err_after", m0_if.err, 0);
        nxt(); smp();
        chk("t4_irq_end", irq, 0);
        chk("t4_idle_grant", grant, 2'b00);
        nxt();

        // ---- 5: ack on the 8th cycle wins over the timeout
        set_m0(1, 1, 0, 32'h0000_0500, 0);
        nxt();
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) begin
                s_if.ack = 1'b1; s_if.dat_r = 32'h8888_0008;
                push(0, 0, 32'h8888_0008);
            end
            smp();
            chk("t5_m0_err", m0_if.err, 0);
            chk("t5_s_stb", s_if.stb, 1);
            nxt();
        end
        s_if.ack = 1'b0; s_if.dat_r = '0;
        set_m0(0, 0, 0, 0, 0);
        smp();
        chk("t5_irq", irq, 0);
        nxt(); smp();
        chk("t5_irq2", irq, 0);
        nxt();

        // ---- 6: reset in the middle of an m1 transfer, late slave ack ignored
        set_m1(1, 1, 0, 32'h0000_0600, 0);
        nxt(); smp();
        chk("t6_grant", grant, 2'b10);
        nxt();
        rstn = 1'b0;
        smp();
        chk("t6_pre_rst_s_cyc", s_if.cyc, 1);
        nxt();
        s_if.ack = 1'b1; s_if.dat_r = 32'hDEAD_BEEF;
        smp();
        chk("t6_s_cyc", s_if.cyc, 0);
        chk("t6_grant_rst", grant, 2'b00);
        chk("t6_m1_ack", m1_if.ack, 0);
        nxt();
        rstn = 1'b1;
        s_if.ack = 1'b0; s_if.dat_r = '0;
        set_m1(0, 0, 0, 0, 0);
        nxt(); nxt(); smp();
        chk("expect_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
